// File: rtl/dna_pkg.sv
// Shared nucleotide types, scan FSM states and the symbol-extract helper used by the encoder
// and by dna_consensus_scan.
package dna_pkg;

  typedef enum logic [1:0] {
    NT_A = 2'b00,
    NT_T = 2'b01,
    NT_G = 2'b10,
    NT_C = 2'b11
  } nucleotide_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StScan = 2'b01,
    StDone = 2'b10
  } scan_state_e;

  // Longest sequence the helper can address; callers zero-extend their packed vectors to MaxW.
  localparam int unsigned MaxSyms = 32;
  localparam int unsigned MaxW    = 2 * MaxSyms;

  // pos is the packed slot (0 = LSBs); symbol i of an N-symbol sequence lives in slot N-1-i.
  function automatic nucleotide_t sym_at(input logic [MaxW-1:0] seq, input int unsigned pos);
    return nucleotide_t'(seq[2*pos +: 2]);
  endfunction

endpackage

// File: rtl/dna_consensus_scan_if.sv
// Handshake and result bundle for dna_consensus_scan. gc_count exists only when
// DNA_GC_COUNT_EN is defined.
interface dna_consensus_scan_if #(
  parameter int unsigned LEN   = 7,
  parameter int unsigned CNT_W = $clog2(LEN + 2)
);
  logic               in_valid;
  logic               in_ready;
  logic [2*LEN+1:0]   seq_a;
  logic [2*LEN+1:0]   seq_b;
  logic [2*LEN+1:0]   seq_c;
  logic               out_valid;
  logic               out_ready;
  logic [2*LEN+1:0]   consensus;
  logic [CNT_W-1:0]   dist_ab;
  logic [CNT_W-1:0]   dist_ac;
  logic [CNT_W-1:0]   dist_bc;
  logic [LEN:0]       tie_mask;
  logic               busy;
`ifdef DNA_GC_COUNT_EN
  logic [CNT_W-1:0]   gc_count;
`endif

  modport slave (
    input  in_valid, seq_a, seq_b, seq_c, out_ready,
    output in_ready, out_valid, consensus, dist_ab, dist_ac, dist_bc, tie_mask, busy
`ifdef DNA_GC_COUNT_EN
    , output gc_count
`endif
  );

  modport master (
    output in_valid, seq_a, seq_b, seq_c, out_ready,
    input  in_ready, out_valid, consensus, dist_ab, dist_ac, dist_bc, tie_mask, busy
`ifdef DNA_GC_COUNT_EN
    , input gc_count
`endif
  );

endinterface

// File: rtl/dna_majority3.sv
// Three-way majority vote on one nucleotide position plus pairwise-differ flags.
// When all three differ, sequence A wins and tie_o is raised.
module dna_majority3
  import dna_pkg::*;
(
  input  nucleotide_t a_i,
  input  nucleotide_t b_i,
  input  nucleotide_t c_i,
  output nucleotide_t cons_o,
  output logic        tie_o,
  output logic        diff_ab_o,
  output logic        diff_ac_o,
  output logic        diff_bc_o
);

  logic diff_ab, diff_ac, diff_bc;

  assign diff_ab = (a_i != b_i);
  assign diff_ac = (a_i != c_i);
  assign diff_bc = (b_i != c_i);

  always_comb begin
    cons_o = a_i;
    tie_o  = 1'b0;
    if (!diff_ab || !diff_ac) begin
      cons_o = a_i;
    end else if (!diff_bc) begin
      cons_o = b_i;
    end else begin
      tie_o = 1'b1;
    end
  end

  assign diff_ab_o = diff_ab;
  assign diff_ac_o = diff_ac;
  assign diff_bc_o = diff_bc;

endmodule

// File: rtl/dna_consensus_scan.sv
// Scans three captured DNA sequences one symbol per cycle, producing consensus, pairwise
// Hamming distances and a tie mask. Optional gc_count output under DNA_GC_COUNT_EN.
module dna_consensus_scan
  import dna_pkg::*;
#(
  parameter int unsigned LEN   = 7,
  parameter int unsigned CNT_W = $clog2(LEN + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  dna_consensus_scan_if.slave   bus
);

  localparam int unsigned W    = 2 * (LEN + 1);
  localparam int unsigned IdxW = (LEN > 1) ? $clog2(LEN + 1) : 1;

  scan_state_e      state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [W-1:0]     seq_a_q, seq_a_d;
  logic [W-1:0]     seq_b_q, seq_b_d;
  logic [W-1:0]     seq_c_q, seq_c_d;
  logic [W-1:0]     cons_q, cons_d;
  logic [CNT_W-1:0] dist_ab_q, dist_ab_d;
  logic [CNT_W-1:0] dist_ac_q, dist_ac_d;
  logic [CNT_W-1:0] dist_bc_q, dist_bc_d;
  logic [LEN:0]     tie_q, tie_d;
  logic [CNT_W-1:0] gc_q, gc_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  int unsigned      pos;
  nucleotide_t      sym_a, sym_b, sym_c, m_cons;
  logic             m_tie, m_diff_ab, m_diff_ac, m_diff_bc;
  logic             m_gc;

  always_comb begin
    pos   = LEN - 32'(idx_q);
    sym_a = sym_at(MaxW'(seq_a_q), pos);
    sym_b = sym_at(MaxW'(seq_b_q), pos);
    sym_c = sym_at(MaxW'(seq_c_q), pos);
  end

  dna_majority3 u_majority (
    .a_i       (sym_a),
    .b_i       (sym_b),
    .c_i       (sym_c),
    .cons_o    (m_cons),
    .tie_o     (m_tie),
    .diff_ab_o (m_diff_ab),
    .diff_ac_o (m_diff_ac),
    .diff_bc_o (m_diff_bc)
  );

  assign m_gc = (m_cons == NT_G) || (m_cons == NT_C);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seq_a_d     = seq_a_q;
    seq_b_d     = seq_b_q;
    seq_c_d     = seq_c_q;
    cons_d      = cons_q;
    dist_ab_d   = dist_ab_q;
    dist_ac_d   = dist_ac_q;
    dist_bc_d   = dist_bc_q;
    tie_d       = tie_q;
    gc_d        = gc_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          seq_a_d    = bus.seq_a;
          seq_b_d    = bus.seq_b;
          seq_c_d    = bus.seq_c;
          cons_d     = '0;
          dist_ab_d  = '0;
          dist_ac_d  = '0;
          dist_bc_d  = '0;
          tie_d      = '0;
          gc_d       = '0;
          idx_d      = '0;
          state_d    = StScan;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StScan: begin
        // Shift results in from the LSB side so symbol 0 ends up at the MSBs after LEN+1 steps.
        cons_d    = {cons_q[W-3:0], m_cons};
        tie_d     = {tie_q[LEN-1:0], m_tie};
        dist_ab_d = dist_ab_q + CNT_W'(m_diff_ab);
        dist_ac_d = dist_ac_q + CNT_W'(m_diff_ac);
        dist_bc_d = dist_bc_q + CNT_W'(m_diff_bc);
        gc_d      = gc_q + CNT_W'(m_gc);
        if (idx_q == IdxW'(LEN)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      seq_a_q     <= '0;
      seq_b_q     <= '0;
      seq_c_q     <= '0;
      cons_q      <= '0;
      dist_ab_q   <= '0;
      dist_ac_q   <= '0;
      dist_bc_q   <= '0;
      tie_q       <= '0;
      gc_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_a_q     <= seq_a_d;
      seq_b_q     <= seq_b_d;
      seq_c_q     <= seq_c_d;
      cons_q      <= cons_d;
      dist_ab_q   <= dist_ab_d;
      dist_ac_q   <= dist_ac_d;
      dist_bc_q   <= dist_bc_d;
      tie_q       <= tie_d;
      gc_q        <= gc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.consensus = cons_q;
  assign bus.dist_ab   = dist_ab_q;
  assign bus.dist_ac   = dist_ac_q;
  assign bus.dist_bc   = dist_bc_q;
  assign bus.tie_mask  = tie_q;
`ifdef DNA_GC_COUNT_EN
  assign bus.gc_count  = gc_q;
`else
  logic unused_gc;
  assign unused_gc = ^gc_q;
`endif

endmodule

// File: tb/tb_dna_consensus_scan.sv
// Randomized self-checking bench for dna_consensus_scan against a vote-counting reference model.
module tb_dna_consensus_scan;

  localparam int unsigned LEN   = 7;
  localparam int unsigned CNT_W = $clog2(LEN + 2);
  localparam int unsigned W     = 2 * (LEN + 1);

  typedef struct packed {
    logic [W-1:0]     cons;
    logic [CNT_W-1:0] dab;
    logic [CNT_W-1:0] dac;
    logic [CNT_W-1:0] dbc;
    logic [LEN:0]     tie;
    logic [CNT_W-1:0] gc;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  int           acc_cyc[$];
  logic [W-1:0] acc_a[$], acc_b[$], acc_c[$];
  res_t         out_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dna_consensus_scan_if #(.LEN(LEN), .CNT_W(CNT_W)) bus ();

  dna_consensus_scan #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Symbol i (0 = first) of a packed sequence.
  function automatic int sym(input logic [W-1:0] s, input int i);
    return int'(s >> (2 * (LEN - i))) & 3;
  endfunction

  function automatic logic [W-1:0] enc(input string s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i <= LEN; i++) begin
      r = r << 2;
      case (s[i])
        "T":     r[1:0] = 2'b01;
        "G":     r[1:0] = 2'b10;
        "C":     r[1:0] = 2'b11;
        default: r[1:0] = 2'b00;
      endcase
    end
    return r;
  endfunction

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c);
    res_t r;
    int   votes[4];
    int   sa, sb, sc, win;
    bit   tie;
    r = '0;
    for (int i = 0; i <= LEN; i++) begin
      sa = sym(a, i);
      sb = sym(b, i);
      sc = sym(c, i);
      for (int v = 0; v < 4; v++) votes[v] = 0;
      votes[sa]++;
      votes[sb]++;
      votes[sc]++;
      win = sa;
      tie = 1'b1;
      for (int v = 0; v < 4; v++) begin
        if (votes[v] >= 2) begin
          win = v;
          tie = 1'b0;
        end
      end
      r.cons = (r.cons << 2) | W'(win);
      r.tie  = (r.tie << 1) | (LEN + 1)'(tie);
      if (sa != sb) r.dab = r.dab + 1'b1;
      if (sa != sc) r.dac = r.dac + 1'b1;
      if (sb != sc) r.dbc = r.dbc + 1'b1;
      if (win >= 2) r.gc = r.gc + 1'b1;
    end
`ifndef DNA_GC_COUNT_EN
    r.gc = '0;
`endif
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.cons = bus.consensus;
    r.dab  = bus.dist_ab;
    r.dac  = bus.dist_ac;
    r.dbc  = bus.dist_bc;
    r.tie  = bus.tie_mask;
`ifdef DNA_GC_COUNT_EN
    r.gc   = bus.gc_count;
`else
    r.gc   = '0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (mon_en && !reset) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc);
        acc_a.push_back(bus.seq_a);
        acc_b.push_back(bus.seq_b);
        acc_c.push_back(bus.seq_c);
      end
      if (bus.out_valid && bus.out_ready) out_q.push_back(observed());
    end
  end

  // Offers a job, scrambles seq_* after accept, and waits for out_valid with out_ready low.
  task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        output int lat, output bit to);
    bit acc;
    int ea;
    int n;
    to  = 1'b0;
    lat = -1;
    acc = 1'b0;
    bus.seq_a = a;
    bus.seq_b = b;
    bus.seq_c = c;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      to = 1'b1;
      return;
    end
    ea = cyc;
    bus.seq_a = W'($urandom);
    bus.seq_b = W'($urandom);
    bus.seq_c = W'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.out_valid) to = 1'b1;
    lat = cyc - ea;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got out_valid=%b busy=%b exp=0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("FAIL reset_results got=%h exp=0", observed());
    end
  endtask

  task automatic test_directed();
    string ta[3] = '{"ATCGCGAA", "ATCGCGAA", "AAAAAAAA"};
    string tb[3] = '{"ATCGCGAA", "ATCCCAAA", "TTTTTTTT"};
    string tc[3] = '{"ATCGCGAA", "AATCCGAA", "GGGGGGGG"};
    res_t  exp;
    int    lat;
    bit    to;
    for (int t = 0; t < 3; t++) begin
      exp = model(enc(ta[t]), enc(tb[t]), enc(tc[t]));
      do_job(enc(ta[t]), enc(tb[t]), enc(tc[t]), lat, to);
      checks++;
      if (to || lat != LEN + 1) begin
        failures++;
        $display("FAIL directed%0d_latency got=%0d exp=%0d timeout=%b", t, lat, LEN + 1, to);
      end
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL directed%0d_result got=%h exp=%h", t, observed(), exp);
      end
      release_out();
    end
    // Independent spot checks of the hand-derived values for the mixed case.
    exp = model(enc("ATCGCGAA"), enc("ATCCCAAA"), enc("AATCCGAA"));
    checks++;
    if (exp.cons !== enc("ATCCCGAA") || exp.dab !== 2 || exp.dac !== 3 || exp.dbc !== 3) begin
      failures++;
      $display("FAIL model_sanity got=%h exp cons=%h", exp, enc("ATCCCGAA"));
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] a, b, c, na, nb, nc;
    res_t exp;
    int   lat, ea, n;
    bit   to;
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    exp = model(a, b, c);
    do_job(a, b, c, lat, to);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      bus.seq_a = W'($urandom);
      bus.seq_b = W'($urandom);
      bus.seq_c = W'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observed() !== exp) begin
        failures++;
        $display("FAIL hold_stable%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h",
                 k, bus.out_valid, bus.in_ready, observed(), exp);
      end
    end
    na = W'($urandom);
    nb = W'($urandom);
    nc = W'($urandom);
    bus.seq_a = na;
    bus.seq_b = nb;
    bus.seq_c = nc;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_idle got ir=%b ov=%b busy=%b exp 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    @(posedge clk);
    #1;
    ea = cyc;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_accept got busy=%b ir=%b exp 1 0", bus.busy, bus.in_ready);
    end
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!bus.out_valid || cyc - ea != LEN + 1 || observed() !== model(na, nb, nc)) begin
      failures++;
      $display("FAIL hold_newjob got ov=%b lat=%0d res=%h exp lat=%0d res=%h",
               bus.out_valid, cyc - ea, observed(), LEN + 1, model(na, nb, nc));
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] a, b, c;
    bit   acc, seen;
    int   lat;
    bit   to;
    acc = 1'b0;
    bus.seq_a = W'($urandom);
    bus.seq_b = W'($urandom);
    bus.seq_c = W'($urandom);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (!acc || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags got acc=%b ir=%b ov=%b busy=%b exp 1 1 0 0",
               acc, bus.in_ready, bus.out_valid, bus.busy);
    end
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("FAIL midreset_results got=%h exp=0", observed());
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen |= bus.out_valid;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midreset_abort got out_valid=1 exp=0");
    end
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    do_job(a, b, c, lat, to);
    checks++;
    if (to || lat != LEN + 1 || observed() !== model(a, b, c)) begin
      failures++;
      $display("FAIL midreset_fresh got lat=%0d to=%b res=%h exp lat=%0d res=%h",
               lat, to, observed(), LEN + 1, model(a, b, c));
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int n;
    acc_cyc.delete();
    acc_a.delete();
    acc_b.delete();
    acc_c.delete();
    out_q.delete();
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 4 && n < 100) begin
      bus.seq_a = W'($urandom);
      bus.seq_b = W'($urandom);
      bus.seq_c = W'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (out_q.size() < acc_cyc.size() && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.out_ready = 1'b0;
    mon_en = 1'b0;
    checks++;
    if (acc_cyc.size() != 4 || out_q.size() != 4) begin
      failures++;
      $display("FAIL b2b_count got acc=%0d out=%0d exp=4 4", acc_cyc.size(), out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          checks++;
          if (acc_cyc[i] - acc_cyc[i-1] != LEN + 3) begin
            failures++;
            $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, acc_cyc[i] - acc_cyc[i-1],
                     LEN + 3);
          end
        end
        checks++;
        if (out_q[i] !== model(acc_a[i], acc_b[i], acc_c[i])) begin
          failures++;
          $display("FAIL b2b_result%0d got=%h exp=%h", i, out_q[i],
                   model(acc_a[i], acc_b[i], acc_c[i]));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, c;
    int   lat;
    bit   to;
    for (int t = 0; t < 8; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      // Make some jobs share symbols heavily so majorities are common.
      if (t[0]) b = (a & W'($urandom)) | (b & ~W'($urandom));
      if (t[1]) c = a ^ (W'(1) << $urandom_range(0, W - 1));
      do_job(a, b, c, lat, to);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      checks++;
      if (to || lat != LEN + 1 || observed() !== model(a, b, c)) begin
        failures++;
        $display("FAIL random%0d got lat=%0d to=%b res=%h exp lat=%0d res=%h",
                 t, lat, to, observed(), LEN + 1, model(a, b, c));
      end
      #1;
      release_out();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.seq_a = '0;
    bus.seq_b = '0;
    bus.seq_c = '0;
    test_reset();
    test_directed();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dna_consensus_scan.md
Name: dna_consensus_scan

Overview:
- Sits directly downstream of the nucleotide encoder.
- Consumes three packed 2-bit-encoded DNA sequences (A, B, C) of LEN+1 symbols each and scans them one symbol per cycle.
- Produces a majority-vote consensus sequence, three pairwise Hamming distances and a per-symbol three-way-mismatch mask.
- Uses a valid/ready handshake on input and output.

Parameters:
- LEN, 7: index of the last symbol; each sequence holds LEN+1 symbols.
- CNT_W, $clog2(LEN+2): width of the distance counters; holds 0..LEN+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input sequences valid
- in_ready  out  1  block can accept input; high only in IDLE
- seq_a  in  2*(LEN+1)  encoded sequence A; symbol i at bits [2*(LEN-i)+1 : 2*(LEN-i)], so symbol 0 is at the MSBs
- seq_b  in  2*(LEN+1)  encoded sequence B, same packing
- seq_c  in  2*(LEN+1)  encoded sequence C, same packing
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- consensus  out  2*(LEN+1)  consensus sequence, same packing
- dist_ab  out  CNT_W  mismatch count between A and B
- dist_ac  out  CNT_W  mismatch count between A and C
- dist_bc  out  CNT_W  mismatch count between B and C
- tie_mask  out  LEN+1  bit LEN-i set when symbol i differs in all three sequences
- busy  out  1  high in SCAN or DONE

Behaviour:
- Encoding: A=00, T=01, G=10, C=11.
- Reset: synchronous, active-high, overrides everything.
  - State goes to IDLE.
  - Symbol index, consensus, all distances, tie_mask, out_valid and busy are cleared to 0.
  - in_ready is 1 from the first cycle after reset deasserts.
  - Reset asserted mid-SCAN or in DONE aborts the job; no result is presented.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture seq_a/b/c into internal registers, clear accumulators, idx=0, go to SCAN.
- SCAN:
  - in_ready=0; each cycle processes symbol idx.
  - Consensus symbol: the value held by at least two of a, b, c. If all three differ, take a's symbol and set the tie_mask bit.
  - Each pairwise counter increments by 1 when its two symbols differ.
  - At idx==LEN, that symbol is processed and the FSM goes to DONE; otherwise idx increments.
- DONE:
  - out_valid=1; all result outputs held stable.
  - On out_ready go to IDLE the next cycle, with out_valid=0.
- Latency: if the input handshake completes in cycle k, SCAN occupies cycles k+1..k+LEN+1 and out_valid first rises in cycle k+LEN+2.
- Throughput: at most one job per LEN+3 cycles (LEN+1 SCAN cycles, ≥1 DONE cycle, 1 IDLE cycle).
- Input captured at accept time; later changes on seq_* during SCAN have no effect.
- in_valid during SCAN or DONE is ignored; no buffering.
- Result outputs are only meaningful while out_valid=1; their values during SCAN are unspecified to the consumer.
- Counters cannot overflow: maximum count LEN+1 fits in CNT_W.

Optional Feature:
- Macro: DNA_GC_COUNT_EN.
- Defined:
  - Adds output gc_count, width CNT_W, counting consensus symbols equal to G or C (code bit1 set).
  - Accumulated during SCAN, cleared on accept and on reset, held in DONE.
- Undefined: gc_count port and logic absent; all other behaviour identical.

Decomposition:
- Shared package dna_pkg:
  - enum nucleotide_t {NT_A=2'b00, NT_T=2'b01, NT_G=2'b10, NT_C=2'b11}
  - FSM state enum
  - symbol-extract helper function, also used by the encoder
- One combinational sub-module, dna_majority3:
  - inputs: three nucleotide_t
  - outputs: consensus symbol, tie flag, three pairwise-differ bits
- FSM, index counter and accumulators live in dna_consensus_scan.

Test Plan:
- Identical input, a=b=c="ATCGCGAA" → consensus ATCGCGAA; all dist=0; tie_mask=0x00; out_valid in cycle k+9.
- a="ATCGCGAA", b="ATCCCAAA", c="AATCCGAA" → consensus ATCCCGAA; dist_ab=2, dist_ac=3, dist_bc=3; tie_mask=0x00; gc_count=4 with DNA_GC_COUNT_EN.
- a="AAAAAAAA", b="TTTTTTTT", c="GGGGGGGG" → consensus AAAAAAAA; all dist=8; tie_mask=0xFF.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new data:
  - outputs stay stable and in_ready=0 throughout;
  - after out_ready=1, one cycle in IDLE, then the new job is accepted.
- Assert reset at SCAN idx=3 → next cycle state IDLE, in_ready=1, out_valid=0, all results 0; a fresh job then completes correctly.
- Back-to-back jobs with in_valid held high → accepts spaced exactly LEN+3 cycles apart; each result matches its own captured input.
